// File: rtl/io_bus_arbiter.sv
// Round-robin owner of the shared peripheral bus with grant locking, a one-cycle idle gap
// between owners and a watchdog that revokes a grant held too long.
module io_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int IONUM   = 3,
  parameter int LEN     = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           rel,
  input  logic [NREQ*IONUM-1:0]     m_en_io,
  input  logic [NREQ*IONUM-1:0]     m_en_cs,
  input  logic [NREQ*LEN-1:0]       m_addr,
  input  logic [NREQ*LEN-1:0]       m_wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [IONUM-1:0]          en_io,
  output logic [IONUM-1:0]          en_cs,
  output logic [LEN-1:0]            addr,
  output logic [LEN-1:0]            wdata,
  input  logic [LEN-1:0]            rdata,
  output logic [LEN-1:0]            m_rdata,
  output logic                      timeout,
  output logic [$clog2(NREQ)-1:0]   timeout_id
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic [IW-1:0]   timeout_id_q, timeout_id_d;

  logic            found;
  logic [IW-1:0]   pick;
  int              idx;
  logic            rel_own;
  logic            wd_hit;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    own_d        = own_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    found        = 1'b0;
    pick         = '0;
    idx          = 0;
    rel_own      = 1'b0;
    wd_hit       = 1'b0;

    // Scan starts just after the last owner so every pending master gets a turn.
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = NREQ'(1) << pick;
          own_d   = pick;
          cnt_d   = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        rel_own = rel[own_q] || !req[own_q];
        wd_hit  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
        if (rel_own || wd_hit) begin
          gnt_d   = '0;
          ptr_d   = own_q;
          state_d = GAP;
          if (!rel_own) begin
            timeout_d    = 1'b1;
            timeout_id_d = own_q;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      own_q        <= '0;
      ptr_q        <= IW'(NREQ - 1);
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      own_q        <= own_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  // One-hot gated OR: nothing reaches the peripherals unless a grant is live.
  always_comb begin
    en_io = '0;
    en_cs = '0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        en_io = en_io | m_en_io[i*IONUM +: IONUM];
        en_cs = en_cs | m_en_cs[i*IONUM +: IONUM];
        addr  = addr  | m_addr[i*LEN +: LEN];
        wdata = wdata | m_wdata[i*LEN +: LEN];
      end
    end
  end

  assign gnt        = gnt_q;
  assign m_rdata    = rdata;
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the peripheral I/O bus (en_io, en_cs, addr, write data) between NREQ bus masters, e.g. the CPU and a DMA/init sequencer, so that SPI_PORT/UART_PORT see exactly one master at a time.
- Sits between the masters and the peripheral ports.
- Arbitration is round-robin with grant locking, a one-cycle idle gap between owners, and a watchdog that revokes a stuck grant.

Parameters:
- NREQ, 2, number of requesting masters (2..8).
- IONUM, 3, number of peripheral enable lines per master (matches CPU_IOC_IONUM).
- LEN, 16, address/data width (same value as `LEN).
- TIMEOUT, 1024, maximum cycles one grant may be held; 0 disables the watchdog.

Ports:
- clk_in  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- req  in  NREQ  per-master bus request, level.
- rel  in  NREQ  per-master release strobe, 1-cycle pulse.
- m_en_io  in  NREQ*IONUM  master i enables at bits [i*IONUM +: IONUM].
- m_en_cs  in  NREQ*IONUM  master i chip-select enables, same packing.
- m_addr  in  NREQ*LEN  master i address at [i*LEN +: LEN].
- m_wdata  in  NREQ*LEN  master i write data at [i*LEN +: LEN].
- gnt  out  NREQ  one-hot grant, registered.
- en_io  out  IONUM  to peripherals.
- en_cs  out  IONUM  to peripherals.
- addr  out  LEN  to peripherals.
- wdata  out  LEN  to peripherals.
- rdata  in  LEN  peripheral read data.
- m_rdata  out  LEN  rdata broadcast to all masters unchanged (combinational).
- timeout  out  1  1-cycle pulse when the watchdog revokes a grant.
- timeout_id  out  clog2(NREQ)  index of the last revoked master; holds until the next revoke.

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, ptr=NREQ-1, hold counter=0, timeout=0, timeout_id=0. All outputs are then 0 except m_rdata.
- State machine: IDLE, OWN, GAP.
- IDLE:
  - If req!=0, pick the first set req bit scanning ptr+1, ptr+2, … modulo NREQ.
  - Set gnt to that one-hot, clear the counter, go to OWN.
  - Latency: req sampled at edge k gives gnt high after edge k.
- OWN (owner g):
  - en_io/en_cs/addr/wdata are a combinational mux of master g's slice.
  - The counter increments each cycle.
  - Leave OWN when rel[g]=1 or req[g]=0. Then gnt becomes 0, ptr=g, next state GAP.
  - Watchdog: if TIMEOUT!=0 and counter==TIMEOUT-1 without release, same exit as a release, plus timeout=1 for one cycle and timeout_id=g.
  - Release and timeout in the same cycle: treat as a release, no timeout pulse.
- GAP: exactly one cycle with gnt=0 and all bus outputs 0, then IDLE. The gap guarantees chip selects deassert between owners.
- Non-owner inputs:
  - rel from any non-owner is ignored.
  - A non-owner's bus inputs never reach the outputs.
  - While gnt=0, all mux outputs are 0.
- Fairness:
  - ptr moves only on release or revoke, so a continuously requesting master cannot win twice while another is pending.
  - A single requester re-wins after each GAP, giving a 2-cycle turnaround from rel to the next gnt.
- Request dropped in the same cycle it would be granted: it is evaluated on the sampled value only; no speculative grant.
- Reset mid-OWN: gnt and the bus outputs drop to 0 immediately (async). The arbiter restarts from IDLE with ptr=NREQ-1, so master 0 has first priority after reset.
- Counter width: clog2(TIMEOUT+1). It saturates and does not wrap when TIMEOUT=0.

Test Plan:
1. Reset, then req=2'b01 at cycle 3 → gnt=01 after edge 3; en_io mirrors m_en_io[2:0]=3'b001; addr = m_addr[15:0]=16'h0040.
2. Both req held, each master pulses rel 4 cycles after its grant → gnt sequence 01, 00 (GAP), 10, 00, 01 …; no two consecutive grants to the same master.
3. Master 1 owns the bus; master 0 drives m_en_cs=3'b111 and pulses rel → outputs unchanged, gnt stays 10.
4. TIMEOUT=8; master 0 holds req with no rel → gnt drops after 8 OWN cycles; timeout=1 for one cycle; timeout_id=0; master 1 (requesting) is granted 2 cycles later.
5. rel asserted exactly on the watchdog cycle (counter=7, TIMEOUT=8) → normal release, timeout stays 0.
6. Assert rst=0 while master 1 owns with en_cs=3'b010 → gnt and en_cs go to 0 without waiting for a clock edge. After release, req=2'b11 grants master 0 first.
